// File: rtl/cam_i2c_pkg.sv
// Shared constants and state encoding for the camera I2C init sequencer.
// Register offsets and command/status bits follow the OpenCores I2C master register map.
package cam_i2c_pkg;

    localparam logic [2:0] REG_PRERLO = 3'd0;
    localparam logic [2:0] REG_PRERHI = 3'd1;
    localparam logic [2:0] REG_CTR    = 3'd2;
    localparam logic [2:0] REG_TXR    = 3'd3;
    localparam logic [2:0] REG_CRSR   = 3'd4;

    localparam logic [7:0] CMD_STA_WR = 8'h90;
    localparam logic [7:0] CMD_WR     = 8'h10;
    localparam logic [7:0] CMD_STO_WR = 8'h50;
    localparam logic [7:0] CMD_STO    = 8'h40;

    localparam int unsigned SR_RXACK = 7;
    localparam int unsigned SR_BUSY  = 6;
    localparam int unsigned SR_AL    = 5;
    localparam int unsigned SR_TIP   = 1;

    localparam logic [7:0]  CTR_EN   = 8'h80;
    localparam logic [15:0] SENTINEL = 16'hFFFF;

    typedef enum logic [3:0] {
        StIdle,
        StCfgLo,
        StCfgHi,
        StCfgCtr,
        StFetch,
        StLatch,
        StTxr,
        StCr,
        StPoll,
        StAlStop,
        StNackStop,
        StNackPoll
    } seq_state_e;

    // Byte 0 opens the transaction with START, byte 3 closes it with STOP.
    function automatic logic [7:0] cr_cmd(input logic [1:0] k);
        unique case (k)
            2'd0:    cr_cmd = CMD_STA_WR;
            2'd3:    cr_cmd = CMD_STO_WR;
            default: cr_cmd = CMD_WR;
        endcase
    endfunction

endpackage

// File: rtl/cam_i2c_init_sequencer_if.sv
// Avalon-MM register bus between the sequencer and the OpenCores I2C master core.
interface cam_i2c_init_sequencer_if;

    logic [2:0] av_address;
    logic       av_write;
    logic       av_read;
    logic [7:0] av_writedata;
    logic [7:0] av_readdata;
    logic       av_waitrequest;

    modport master (
        output av_address,
        output av_write,
        output av_read,
        output av_writedata,
        input  av_readdata,
        input  av_waitrequest
    );

    modport slave (
        input  av_address,
        input  av_write,
        input  av_read,
        input  av_writedata,
        output av_readdata,
        output av_waitrequest
    );

endinterface

// File: rtl/avmm_single_xfer.sv
// Single outstanding Avalon-MM transfer: latches a request, holds the strobe through
// waitrequest and pulses ack on completion. The requester keeps req high until ack.
module avmm_single_xfer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req,
    input  logic       req_wr,
    input  logic [2:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       ack,
    output logic [7:0] rdata,
    cam_i2c_init_sequencer_if.master av
);

    logic       write_q, write_d;
    logic       read_q, read_d;
    logic [2:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       active;

    assign active = write_q | read_q;
    assign ack    = active & ~av.av_waitrequest;
    assign rdata  = av.av_readdata;

    // A request is only accepted while no strobe is up, so the ack cycle never re-issues.
    always_comb begin
        write_d = write_q;
        read_d  = read_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (ack) begin
            write_d = 1'b0;
            read_d  = 1'b0;
        end else if (!active && req) begin
            write_d = req_wr;
            read_d  = ~req_wr;
            addr_d  = req_addr;
            wdata_d = req_wr ? req_wdata : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            write_q <= 1'b0;
            read_q  <= 1'b0;
            addr_q  <= 3'd0;
            wdata_q <= 8'h00;
        end else begin
            write_q <= write_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign av.av_write     = write_q;
    assign av.av_read      = read_q;
    assign av.av_address   = addr_q;
    assign av.av_writedata = wdata_q;

endmodule

// File: rtl/cam_i2c_init_sequencer.sv
// Power-up configuration of the D8M sensor: programs the I2C core, then writes each
// {reg_addr, reg_data} table entry as a 4-byte I2C write, retrying on NACK.
module cam_i2c_init_sequencer
    import cam_i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR  = 7'h36,
    parameter logic [15:0] PRESCALE  = 16'd99,
    parameter int unsigned TBL_AW    = 8,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [TBL_AW-1:0] err_index,
    cam_i2c_init_sequencer_if.master av,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [23:0]       tbl_data
);

    localparam int unsigned RetryW = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;

    seq_state_e state_q, state_d;

    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [TBL_AW-1:0] err_index_q, err_index_d;
    logic [TBL_AW-1:0] index_q, index_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic [1:0]        byte_q, byte_d;
    logic [23:0]       entry_q, entry_d;

    logic       req, req_wr, ack;
    logic [2:0] req_addr;
    logic [7:0] req_wdata, rdata, txr_byte;
    logic       poll_ok, stop_ok, is_sentinel, last_idx, last_byte, can_retry;
    logic       unused_sr;

    assign poll_ok     = ack & ~rdata[SR_TIP];
    assign stop_ok     = ack & ~rdata[SR_BUSY];
    assign is_sentinel = (tbl_data[23:8] == SENTINEL);
    assign last_idx    = &index_q;
    assign last_byte   = (byte_q == 2'd3);
    assign can_retry   = (retry_q < RetryW'(MAX_RETRY));
    assign unused_sr   = ^{rdata[4:2], rdata[0]};

    assign txr_byte = (byte_q == 2'd0) ? {DEV_ADDR, 1'b0} :
                      (byte_q == 2'd1) ? entry_q[23:16]   :
                      (byte_q == 2'd2) ? entry_q[15:8]    : entry_q[7:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (start) state_d = StCfgLo;
            StCfgLo:    if (ack) state_d = StCfgHi;
            StCfgHi:    if (ack) state_d = StCfgCtr;
            StCfgCtr:   if (ack) state_d = StFetch;
            StFetch:    state_d = StLatch;
            StLatch:    state_d = is_sentinel ? StIdle : StTxr;
            StTxr:      if (ack) state_d = StCr;
            StCr:       if (ack) state_d = StPoll;
            StPoll: begin
                if (poll_ok) begin
                    if (rdata[SR_AL])         state_d = StAlStop;
                    else if (rdata[SR_RXACK]) state_d = StNackStop;
                    else if (!last_byte)      state_d = StTxr;
                    else if (last_idx)        state_d = StIdle;
                    else                      state_d = StFetch;
                end
            end
            StAlStop:   if (ack) state_d = StIdle;
            StNackStop: if (ack) state_d = StNackPoll;
            StNackPoll: if (stop_ok) state_d = can_retry ? StTxr : StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q != StIdle);
        req       = 1'b0;
        req_wr    = 1'b0;
        req_addr  = REG_PRERLO;
        req_wdata = 8'h00;
        case (state_q)
            StCfgLo:    begin req = 1'b1; req_wr = 1'b1; req_addr = REG_PRERLO;
                              req_wdata = PRESCALE[7:0]; end
            StCfgHi:    begin req = 1'b1; req_wr = 1'b1; req_addr = REG_PRERHI;
                              req_wdata = PRESCALE[15:8]; end
            StCfgCtr:   begin req = 1'b1; req_wr = 1'b1; req_addr = REG_CTR;
                              req_wdata = CTR_EN; end
            StTxr:      begin req = 1'b1; req_wr = 1'b1; req_addr = REG_TXR;
                              req_wdata = txr_byte; end
            StCr:       begin req = 1'b1; req_wr = 1'b1; req_addr = REG_CRSR;
                              req_wdata = cr_cmd(byte_q); end
            StAlStop,
            StNackStop: begin req = 1'b1; req_wr = 1'b1; req_addr = REG_CRSR;
                              req_wdata = CMD_STO; end
            StPoll,
            StNackPoll: begin req = 1'b1; req_addr = REG_CRSR; end
            default:    ;
        endcase
    end

    always_comb begin
        done_d      = done_q;
        error_d     = error_q;
        err_index_d = err_index_q;
        index_d     = index_q;
        retry_d     = retry_q;
        byte_d      = byte_q;
        entry_d     = entry_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    err_index_d = '0;
                    index_d     = '0;
                    retry_d     = '0;
                end
            end
            StLatch: begin
                entry_d = tbl_data;
                byte_d  = 2'd0;
                if (is_sentinel) done_d = 1'b1;
            end
            StPoll: begin
                if (poll_ok && !rdata[SR_AL] && !rdata[SR_RXACK]) begin
                    if (!last_byte) begin
                        byte_d = byte_q + 2'd1;
                    end else begin
                        retry_d = '0;
                        // The last table slot ends the run rather than wrapping to index 0.
                        if (last_idx) done_d = 1'b1;
                        else          index_d = index_q + TBL_AW'(1);
                    end
                end
            end
            StAlStop: begin
                if (ack) begin
                    error_d     = 1'b1;
                    err_index_d = index_q;
                end
            end
            StNackPoll: begin
                if (stop_ok) begin
                    if (can_retry) begin
                        retry_d = retry_q + RetryW'(1);
                        byte_d  = 2'd0;
                    end else begin
                        error_d     = 1'b1;
                        err_index_d = index_q;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= '0;
            index_q     <= '0;
            retry_q     <= '0;
            byte_q      <= 2'd0;
            entry_q     <= 24'h0;
        end else begin
            done_q      <= done_d;
            error_q     <= error_d;
            err_index_q <= err_index_d;
            index_q     <= index_d;
            retry_q     <= retry_d;
            byte_q      <= byte_d;
            entry_q     <= entry_d;
        end
    end

    assign done      = done_q;
    assign error     = error_q;
    assign err_index = err_index_q;
    assign tbl_addr  = index_q;

    avmm_single_xfer u_xfer (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .rdata     (rdata),
        .av        (av)
    );

endmodule

// File: tb/tb_cam_i2c_init_sequencer.sv
// Directed bench: an I2C-core register model with random waitrequest logs every write,
// and each scenario's write stream and status outputs are checked against fixed tables.
module tb_cam_i2c_init_sequencer;

    logic clk = 1'b0;
    logic reset_n, start1, start2, sel2;
    logic busy1, done1, error1, busy2, done2, error2;
    logic [7:0] err_idx1, tbl_addr1;
    logic [1:0] err_idx2, tbl_addr2;
    logic [23:0] tbl_q;
    logic [23:0] tbl [256];

    cam_i2c_init_sequencer_if bus1 ();
    cam_i2c_init_sequencer_if bus2 ();

    cam_i2c_init_sequencer dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .busy(busy1), .done(done1),
        .error(error1), .err_index(err_idx1), .av(bus1.master), .tbl_addr(tbl_addr1),
        .tbl_data(tbl_q)
    );

    cam_i2c_init_sequencer #(.TBL_AW(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .busy(busy2), .done(done2),
        .error(error2), .err_index(err_idx2), .av(bus2.master), .tbl_addr(tbl_addr2),
        .tbl_data(tbl_q)
    );

    always #10 clk = ~clk;

    // I2C core model
    logic       m_write, m_read, m_wait, rx, al_flag, al_given;
    logic [2:0] m_addr;
    logic [7:0] m_wdata, m_sr, txr_q;
    logic [1:0] wcnt, tip_cnt, busy_cnt;
    int         sta_nacked, cfg_sta_nacks;
    bit         cfg_nack_txr, cfg_al;
    logic [10:0] log_q [$];

    assign m_write = sel2 ? bus2.av_write : bus1.av_write;
    assign m_read  = sel2 ? bus2.av_read : bus1.av_read;
    assign m_addr  = sel2 ? bus2.av_address : bus1.av_address;
    assign m_wdata = sel2 ? bus2.av_writedata : bus1.av_writedata;
    assign m_wait  = (m_write || m_read) && (wcnt != 2'd0);
    assign m_sr    = {rx, busy_cnt != 2'd0, al_flag, 3'b000, tip_cnt != 2'd0, 1'b0};
    assign bus1.av_waitrequest = m_wait;
    assign bus2.av_waitrequest = m_wait;
    assign bus1.av_readdata    = m_sr;
    assign bus2.av_readdata    = m_sr;

    always @(posedge clk) tbl_q <= tbl[sel2 ? {6'd0, tbl_addr2} : tbl_addr1];

    always @(posedge clk) begin
        if (!reset_n) begin
            wcnt <= 2'd0; tip_cnt <= 2'd0; busy_cnt <= 2'd0; rx <= 1'b0;
            al_flag <= 1'b0; al_given <= 1'b0; sta_nacked <= 0; txr_q <= 8'h00;
        end else begin
            if (!(m_write || m_read)) wcnt <= 2'($urandom_range(0, 3));
            else if (wcnt != 2'd0)    wcnt <= wcnt - 2'd1;
            if ((m_write || m_read) && !m_wait) begin
                if (m_write) begin
                    log_q.push_back({m_addr, m_wdata});
                    if (m_addr == 3'd3) txr_q <= m_wdata;
                    if (m_addr == 3'd4 && m_wdata[4]) begin
                        tip_cnt <= 2'd1;
                        if (m_wdata[7]) begin
                            rx <= (sta_nacked < cfg_sta_nacks);
                            if (sta_nacked < cfg_sta_nacks) sta_nacked <= sta_nacked + 1;
                        end else begin
                            rx <= cfg_nack_txr && (m_wdata == 8'h10) && (txr_q == 8'h3A);
                        end
                        if (cfg_al && !al_given) begin
                            al_flag  <= 1'b1;
                            al_given <= 1'b1;
                        end
                    end
                    if (m_addr == 3'd4 && m_wdata == 8'h40) begin
                        busy_cnt <= 2'd1;
                        al_flag  <= 1'b0;
                    end
                end else begin
                    if (tip_cnt != 2'd0)       tip_cnt <= tip_cnt - 2'd1;
                    else if (busy_cnt != 2'd0) busy_cnt <= busy_cnt - 2'd1;
                end
            end
        end
    end

    int n_cmp = 0;
    int n_mis = 0;
    int base;
    logic [10:0] exp1 [11] = '{11'h063, 11'h100, 11'h280, 11'h36C, 11'h490, 11'h301,
                               11'h410, 11'h300, 11'h410, 11'h301, 11'h450};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    function automatic int count_of(input int from, input logic [10:0] val);
        int n = 0;
        for (int i = from; i < log_q.size(); i++) if (log_q[i] === val) n++;
        return n;
    endfunction

    function automatic logic [10:0] log_at(input int i);
        if (i >= 0 && i < log_q.size()) return log_q[i];
        return 11'h7FF;
    endfunction

    task automatic check_exp1(input string tag, input int from, input int first);
        for (int i = first; i < 11; i++)
            check($sformatf("%s[%0d]", tag, i), 32'(log_at(from + i - first)), 32'(exp1[i]));
    endtask

    task automatic pulse_start(input bit second);
        @(negedge clk);
        if (second) start2 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_idle(input bit second, input string tag);
        for (int i = 0; i < 5000; i++) begin
            if (!(second ? busy2 : busy1)) break;
            @(negedge clk);
        end
        check(tag, 32'(second ? busy2 : busy1), 32'd0);
    endtask

    task automatic wait_read(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (bus1.av_read) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    function automatic logic [31:0] outs1();
        return {busy1, done1, error1, err_idx1, bus1.av_write, bus1.av_read, bus1.av_address,
                bus1.av_writedata, tbl_addr1};
    endfunction

    initial begin
        reset_n = 1'b0; start1 = 1'b0; start2 = 1'b0; sel2 = 1'b0;
        cfg_sta_nacks = 0; cfg_nack_txr = 1'b0; cfg_al = 1'b0;
        for (int i = 0; i < 256; i++) tbl[i] = 24'hFFFF00;
        tbl[0] = 24'h010001;
        tbl[1] = 24'hFFFF00;
        repeat (3) @(negedge clk);
        check("reset_outs", outs1(), 32'd0);
        reset_n = 1'b1;

        // Single entry, all ACK
        base = log_q.size();
        pulse_start(1'b0);
        check("t1_busy", 32'(busy1), 32'd1);
        wait_idle(1'b0, "t1_timeout");
        check("t1_nwr", 32'(log_q.size() - base), 32'd11);
        check_exp1("t1_wr", base, 0);
        check("t1_done_err", {done1, error1}, 32'b10);
        check("t1_tbl_addr", 32'(tbl_addr1), 32'd1);

        // Two NACKs on the device-address byte, then ACK
        cfg_sta_nacks = 2;
        base = log_q.size();
        pulse_start(1'b0);
        wait_idle(1'b0, "t2_timeout");
        check("t2_nwr", 32'(log_q.size() - base), 32'd17);
        check("t2_stops", 32'(count_of(base, 11'h440)), 32'd2);
        check("t2_starts", 32'(count_of(base, 11'h490)), 32'd3);
        check_exp1("t2_tail", base + 9, 3);
        check("t2_done_err", {done1, error1}, 32'b10);

        // Persistent NACK on entry 2
        cfg_sta_nacks = 0;
        cfg_nack_txr  = 1'b1;
        tbl[0] = 24'h112233; tbl[1] = 24'h445566; tbl[2] = 24'h3A5B77; tbl[3] = 24'hFFFF00;
        base = log_q.size();
        pulse_start(1'b0);
        wait_idle(1'b0, "t3_timeout");
        check("t3_nwr", 32'(log_q.size() - base), 32'd39);
        check("t3_stops", 32'(count_of(base, 11'h440)), 32'd4);
        check("t3_attempts", 32'(count_of(base, 11'h33A)), 32'd4);
        check("t3_status", {busy1, done1, error1}, 32'b001);
        check("t3_err_index", 32'(err_idx1), 32'd2);

        // Arbitration lost during entry 0
        cfg_nack_txr = 1'b0;
        cfg_al       = 1'b1;
        base = log_q.size();
        pulse_start(1'b0);
        wait_idle(1'b0, "t4_timeout");
        check("t4_nwr", 32'(log_q.size() - base), 32'd6);
        check("t4_last", 32'(log_at(log_q.size() - 1)), 32'h440);
        check("t4_status", {done1, error1}, 32'b01);
        check("t4_err_index", 32'(err_idx1), 32'd0);

        // start while busy is ignored; reset mid-POLL recovers cleanly
        cfg_al = 1'b0;
        tbl[0] = 24'h010001; tbl[1] = 24'hFFFF00;
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        base = log_q.size();
        pulse_start(1'b0);
        wait_read("t5_poll_a");
        pulse_start(1'b0);
        check("t5_busy_hold", 32'(busy1), 32'd1);
        wait_idle(1'b0, "t5_timeout_a");
        check("t5_nwr_a", 32'(log_q.size() - base), 32'd11);
        check_exp1("t5_wr_a", base, 0);
        pulse_start(1'b0);
        wait_read("t5_poll_b");
        reset_n = 1'b0;
        @(negedge clk);
        check("t5_reset_outs", outs1(), 32'd0);
        reset_n = 1'b1;
        base = log_q.size();
        pulse_start(1'b0);
        wait_idle(1'b0, "t5_timeout_c");
        check("t5_nwr_c", 32'(log_q.size() - base), 32'd11);
        check_exp1("t5_wr_c", base, 0);
        check("t5_done", 32'(done1), 32'd1);

        // TBL_AW=2 with no sentinel: stop after the last slot
        sel2 = 1'b1;
        tbl[0] = 24'h112233; tbl[1] = 24'h445566; tbl[2] = 24'h778899; tbl[3] = 24'hAABBCC;
        base = log_q.size();
        pulse_start(1'b1);
        wait_idle(1'b1, "t6_timeout");
        check("t6_nwr", 32'(log_q.size() - base), 32'd35);
        check("t6_entries", 32'(count_of(base, 11'h36C)), 32'd4);
        check("t6_idx0_once", 32'(count_of(base, 11'h311)), 32'd1);
        check("t6_last_data", 32'(log_at(log_q.size() - 2)), 32'h3CC);
        check("t6_status", {done2, error2}, 32'b10);
        check("t6_tbl_addr", 32'(tbl_addr2), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
